selftest_ctrl: RTL and testbench
================================

Name: selftest_ctrl

Overview:
- Synthesizable on-chip self-test sequencer for riscv_pipeline; the parametrised successor to the simulation-only program-load-and-check flow.
- Copies a program image from a ROM source into core instruction memory while holding the core in reset, releases reset for a bounded run, then reads back registers and data memory through a debug port.
- Compares readback against a parametrised check table and reports pass/fail, error count and first failing entry. Sits beside the core.

Parameters:
XLEN, 32, data/instruction width
PROG_DEPTH, 256, words copied into instruction memory (power of 2)
NUM_CHECKS, 8, check-table entries evaluated
RUN_CYCLES, 60, core run cycles after reset release
RESET_HOLD, 2, cycles core_rst stays high after load completes
DBG_TIMEOUT, 16, max cycles waiting for dbg_valid

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a test sequence
prog_addr  out  $clog2(PROG_DEPTH)  program source read address
prog_rdata  in  XLEN  program word; valid 1 cycle after prog_addr
imem_we  out  1  instruction memory write enable
imem_addr  out  $clog2(PROG_DEPTH)  instruction memory word address
imem_wdata  out  XLEN  instruction word
core_rst  out  1  core reset, active-high
chk_addr  out  $clog2(NUM_CHECKS)  check-table read address
chk_is_mem  in  1  entry kind: 0=register, 1=data memory; valid 1 cycle after chk_addr
chk_index  in  XLEN  register number (low 5 bits) or byte address
chk_expect  in  XLEN  expected value
dbg_req  out  1  debug read request, single-cycle pulse
dbg_is_mem  out  1  request kind
dbg_addr  out  XLEN  register number, or word index = byte address >> 2
dbg_rdata  in  XLEN  readback data
dbg_valid  in  1  readback valid
busy  out  1  sequence in progress
done  out  1  sticky; set at end of sequence
pass  out  1  valid when done; 1 iff err_count==0
err_count  out  $clog2(NUM_CHECKS+1)  mismatches plus timeouts
first_fail  out  $clog2(NUM_CHECKS)  index of first failing entry; 0 if none

Behaviour:
- Reset values: state IDLE; core_rst=1, imem_we=0, dbg_req=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, all address outputs 0.
- IDLE: core_rst=1. On start, clear done/pass/err_count/first_fail, set busy, go to LOAD.
- LOAD: prog_addr counts 0..PROG_DEPTH-1, one per cycle. imem_we is asserted one cycle later with imem_addr = the previous prog_addr and imem_wdata = prog_rdata. Exactly PROG_DEPTH writes occur; the phase lasts PROG_DEPTH+1 cycles; the counter must not wrap.
- HOLD: core_rst=1 for RESET_HOLD cycles, then go to RUN.
- RUN: core_rst=0 for exactly RUN_CYCLES cycles, then core_rst=1 again and go to CHECK.
- CHECK, per entry i in 0..NUM_CHECKS-1:
  - Drive chk_addr=i. Next cycle, pulse dbg_req with dbg_is_mem=chk_is_mem.
  - dbg_addr = chk_index>>2 for memory entries; {27'b0, chk_index[4:0]} for register entries.
  - Wait for dbg_valid; compare dbg_rdata against chk_expect (full XLEN).
  - On mismatch, or no dbg_valid within DBG_TIMEOUT cycles after dbg_req: increment err_count; if this is the first error, set first_fail=i.
  - dbg_valid arriving in the same cycle as dbg_req is ignored. dbg_valid arriving while not waiting is ignored.
- DONE: done=1, pass=(err_count==0), busy=0, core_rst=1; return to IDLE. done/pass hold until the next start.
- start while busy is ignored.
- rst_n low mid-sequence: immediate abort to reset values. No partial result is reported.

Optional Feature:
SELFTEST_EARLY_EXIT_EN
- Enabled: adds input core_halted (1 bit) and output run_cycles_used ($clog2(RUN_CYCLES+1), reset 0).
  - core_halted high during RUN ends RUN at the end of that cycle and moves to CHECK.
  - run_cycles_used records cycles spent in RUN, including the halting cycle; RUN_CYCLES if no halt.
- Disabled: neither port exists; RUN always lasts RUN_CYCLES.

Decomposition:
- Package selftest_pkg: state enum (IDLE, LOAD, HOLD, RUN, CHECK, DONE); check-kind constants CHK_REG=0, CHK_MEM=1; check sub-state enum (FETCH, REQ, WAIT).
- One sub-module, selftest_checker: owns the per-entry FETCH/REQ/WAIT handshake, the timeout counter and the compare. It returns per-entry result strobe and fail flag to the top FSM.

Test Plan:
- PROG_DEPTH=8, ROM word k = 0x100+k; pulse start -> imem_we asserted 8 consecutive cycles, addr 0..7, data 0x100..0x107; core_rst high through LOAD and RESET_HOLD cycles.
- Debug model returns x1=5, x2=7, x3=12, x4=12, x5=55, mem byte addr 10 = 12; checks expect those values -> dbg_addr for mem entry = 2; done=1, pass=1, err_count=0.
- Same setup but expect x5=99 at entry 4 and mem=13 at entry 5 -> err_count=2, first_fail=4, pass=0.
- Debug model never raises dbg_valid for entry 2 -> timeout DBG_TIMEOUT cycles after dbg_req, err_count=1, first_fail=2, remaining entries still evaluated.
- rst_n low during RUN cycle 10, then start again -> all outputs at reset values; second run completes with a full LOAD.
- SELFTEST_EARLY_EXIT_EN defined, core_halted pulsed at RUN cycle 20 -> CHECK begins next cycle, run_cycles_used=20; start during busy has no effect.

Source files
------------

// File: rtl/selftest_pkg.sv
// Shared encodings for the self-test sequencer: top-level phases, check sub-states
// and check-entry kinds.
package selftest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    CK_FETCH,
    CK_REQ,
    CK_WAIT
  } chk_state_t;

  localparam logic CHK_REG = 1'b0;
  localparam logic CHK_MEM = 1'b1;

endpackage

// File: rtl/selftest_if.sv
// Check-table read port plus core debug read port used during the CHECK phase.
interface selftest_if #(
  parameter int XLEN = 32,
  parameter int CAW  = 3
);
  logic [CAW-1:0]  chk_addr;
  logic            chk_is_mem;
  logic [XLEN-1:0] chk_index;
  logic [XLEN-1:0] chk_expect;
  logic            dbg_req;
  logic            dbg_is_mem;
  logic [XLEN-1:0] dbg_addr;
  logic [XLEN-1:0] dbg_rdata;
  logic            dbg_valid;

  modport master (
    output chk_addr, dbg_req, dbg_is_mem, dbg_addr,
    input  chk_is_mem, chk_index, chk_expect, dbg_rdata, dbg_valid
  );

  modport slave (
    input  chk_addr, dbg_req, dbg_is_mem, dbg_addr,
    output chk_is_mem, chk_index, chk_expect, dbg_rdata, dbg_valid
  );
endinterface

// File: rtl/selftest_checker.sv
// Walks the check table: fetch entry, issue one debug read, wait (bounded) for the
// readback and report a per-entry pass/fail strobe to the sequencer.
module selftest_checker
  import selftest_pkg::*;
#(
  parameter int  XLEN        = 32,
  parameter int  NUM_CHECKS  = 8,
  parameter int  DBG_TIMEOUT = 16,
  localparam int CAW         = $clog2(NUM_CHECKS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  selftest_if.master     bus,
  output logic           o_res_valid,
  output logic           o_res_fail,
  output logic           o_res_last,
  output logic [CAW-1:0] o_res_idx
);

  localparam int TW = $clog2(DBG_TIMEOUT + 1);

  chk_state_t      r_state;
  logic            r_active;
  logic [CAW-1:0]  r_idx;
  logic [TW-1:0]   r_to;
  logic [XLEN-1:0] r_expect;
  logic            r_req;
  logic            r_is_mem;
  logic [XLEN-1:0] r_dbg_addr;
  logic            r_res_valid;
  logic            r_res_fail;
  logic            r_res_last;
  logic [CAW-1:0]  r_res_idx;
  logic            w_got;
  logic            w_tmo;
  logic            w_last;

  function automatic logic [XLEN-1:0] dbg_addr_of(input logic is_mem,
                                                  input logic [XLEN-1:0] idx);
    case (is_mem)
      CHK_MEM: dbg_addr_of = idx >> 2;
      CHK_REG: dbg_addr_of = XLEN'(idx[4:0]);
      default: dbg_addr_of = '0;
    endcase
  endfunction

  // r_to==0 is the request cycle itself, where a readback is not accepted.
  assign w_got  = (r_state == CK_WAIT) && (r_to != '0) && bus.dbg_valid;
  assign w_tmo  = (r_state == CK_WAIT) && !w_got && (r_to == TW'(DBG_TIMEOUT));
  assign w_last = (r_idx == CAW'(NUM_CHECKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CK_FETCH;
      r_active    <= 1'b0;
      r_idx       <= '0;
      r_to        <= '0;
      r_expect    <= '0;
      r_req       <= 1'b0;
      r_is_mem    <= 1'b0;
      r_dbg_addr  <= '0;
      r_res_valid <= 1'b0;
      r_res_fail  <= 1'b0;
      r_res_last  <= 1'b0;
      r_res_idx   <= '0;
    end else begin
      r_req       <= 1'b0;
      r_res_valid <= 1'b0;
      if (i_start) begin
        r_active <= 1'b1;
        r_idx    <= '0;
        r_state  <= CK_FETCH;
      end else begin
        case (r_state)
          CK_FETCH: if (r_active) r_state <= CK_REQ;
          CK_REQ: begin
            r_req      <= 1'b1;
            r_is_mem   <= bus.chk_is_mem;
            r_dbg_addr <= dbg_addr_of(bus.chk_is_mem, bus.chk_index);
            r_expect   <= bus.chk_expect;
            r_to       <= '0;
            r_state    <= CK_WAIT;
          end
          CK_WAIT: begin
            if (w_got || w_tmo) begin
              r_res_valid <= 1'b1;
              r_res_fail  <= w_tmo || (bus.dbg_rdata != r_expect);
              r_res_idx   <= r_idx;
              r_res_last  <= w_last;
              r_state     <= CK_FETCH;
              if (w_last) r_active <= 1'b0;
              else        r_idx    <= r_idx + 1'b1;
            end else begin
              r_to <= r_to + 1'b1;
            end
          end
          default: r_state <= CK_FETCH;
        endcase
      end
    end
  end

  assign bus.chk_addr   = r_idx;
  assign bus.dbg_req    = r_req;
  assign bus.dbg_is_mem = r_is_mem;
  assign bus.dbg_addr   = r_dbg_addr;
  assign o_res_valid    = r_res_valid;
  assign o_res_fail     = r_res_fail;
  assign o_res_last     = r_res_last;
  assign o_res_idx      = r_res_idx;

endmodule

// File: rtl/selftest_ctrl.sv
// Self-test sequencer: load program image, hold/release core reset, then check results.
// Build option SELFTEST_EARLY_EXIT_EN adds core_halted early exit and run_cycles_used.
module selftest_ctrl
  import selftest_pkg::*;
#(
  parameter int  XLEN        = 32,
  parameter int  PROG_DEPTH  = 256,
  parameter int  NUM_CHECKS  = 8,
  parameter int  RUN_CYCLES  = 60,
  parameter int  RESET_HOLD  = 2,
  parameter int  DBG_TIMEOUT = 16,
  localparam int PAW         = $clog2(PROG_DEPTH),
  localparam int CAW         = $clog2(NUM_CHECKS),
  localparam int EW          = $clog2(NUM_CHECKS + 1),
  localparam int RW          = $clog2(RUN_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  output logic [PAW-1:0]  o_prog_addr,
  input  logic [XLEN-1:0] i_prog_rdata,
  output logic            o_imem_we,
  output logic [PAW-1:0]  o_imem_addr,
  output logic [XLEN-1:0] o_imem_wdata,
  output logic            o_core_rst,
  selftest_if.master      bus,
`ifdef SELFTEST_EARLY_EXIT_EN
  input  logic            i_core_halted,
  output logic [RW-1:0]   o_run_cycles_used,
`endif
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [EW-1:0]   o_err_count,
  output logic [CAW-1:0]  o_first_fail
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam int CW = (RW > HW) ? RW : HW;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_pa_valid;
  logic [PAW-1:0] r_prog_addr;
  logic           r_imem_we;
  logic [PAW-1:0] r_imem_addr;
  logic           r_core_rst;
  logic           r_busy;
  logic           r_done;
  logic           r_pass;
  logic [EW-1:0]  r_err;
  logic [CAW-1:0] r_ff;
  logic [RW-1:0]  r_used;
  logic           w_halt;
  logic           w_run_end;
  logic           w_res_valid;
  logic           w_res_fail;
  logic           w_res_last;
  logic [CAW-1:0] w_res_idx;

`ifdef SELFTEST_EARLY_EXIT_EN
  assign w_halt            = i_core_halted;
  assign o_run_cycles_used = r_used;
`else
  assign w_halt = 1'b0;
`endif

  assign w_run_end = (r_state == ST_RUN) && (w_halt || (r_cnt == CW'(RUN_CYCLES - 1)));

  selftest_checker #(
    .XLEN       (XLEN),
    .NUM_CHECKS (NUM_CHECKS),
    .DBG_TIMEOUT(DBG_TIMEOUT)
  ) u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_run_end),
    .bus        (bus),
    .o_res_valid(w_res_valid),
    .o_res_fail (w_res_fail),
    .o_res_last (w_res_last),
    .o_res_idx  (w_res_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pa_valid  <= 1'b0;
      r_prog_addr <= '0;
      r_imem_we   <= 1'b0;
      r_imem_addr <= '0;
      r_core_rst  <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_ff        <= '0;
      r_used      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_core_rst <= 1'b1;
          if (i_start) begin
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err       <= '0;
            r_ff        <= '0;
            r_used      <= '0;
            r_busy      <= 1'b1;
            r_prog_addr <= '0;
            r_pa_valid  <= 1'b1;
            r_state     <= ST_LOAD;
          end
        end
        // Writes trail the ROM address by one cycle; the final cycle drains the last word.
        ST_LOAD: begin
          r_imem_we   <= r_pa_valid;
          r_imem_addr <= r_prog_addr;
          if (r_pa_valid) begin
            if (r_prog_addr == PAW'(PROG_DEPTH - 1)) r_pa_valid  <= 1'b0;
            else                                     r_prog_addr <= r_prog_addr + 1'b1;
          end else begin
            r_prog_addr <= '0;
            r_cnt       <= '0;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_cnt == CW'(RESET_HOLD - 1)) begin
            r_cnt      <= '0;
            r_core_rst <= 1'b0;
            r_state    <= ST_RUN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (w_run_end) begin
            r_core_rst <= 1'b1;
            r_used     <= RW'(r_cnt) + RW'(1);
            r_state    <= ST_CHECK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_res_valid) begin
            if (w_res_fail) begin
              r_err <= r_err + 1'b1;
              if (r_err == '0) r_ff <= w_res_idx;
            end
            if (w_res_last) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done     <= 1'b1;
          r_pass     <= (r_err == '0);
          r_busy     <= 1'b0;
          r_core_rst <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ROM data arrives one cycle after its address, aligned with the registered write strobe.
  assign o_imem_wdata = i_prog_rdata;
  assign o_prog_addr  = r_prog_addr;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_core_rst   = r_core_rst;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_err_count  = r_err;
  assign o_first_fail = r_ff;

endmodule

// File: tb/tb_selftest_ctrl.sv
// Directed bench for selftest_ctrl: ROM, check table and debug-port models with
// per-entry response latency; early-exit scenario under SELFTEST_EARLY_EXIT_EN.
module tb_selftest_ctrl;
  import selftest_pkg::*;

  localparam int PD  = 8;
  localparam int NC  = 8;
  localparam int RUN = 60;
  localparam int HLD = 2;
  localparam int TO  = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  prog_addr;
  logic [31:0] prog_rdata = '0;
  logic        imem_we;
  logic [2:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst, busy, done, pass;
  logic [3:0]  err_count;
  logic [2:0]  first_fail;
`ifdef SELFTEST_EARLY_EXIT_EN
  logic        core_halted = 1'b0;
  logic [5:0]  run_used;
`endif

  selftest_if #(.XLEN(32), .CAW(3)) bus ();

  selftest_ctrl #(
    .XLEN(32), .PROG_DEPTH(PD), .NUM_CHECKS(NC),
    .RUN_CYCLES(RUN), .RESET_HOLD(HLD), .DBG_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start),
    .o_prog_addr(prog_addr), .i_prog_rdata(prog_rdata),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
    .o_core_rst(core_rst), .bus(bus),
`ifdef SELFTEST_EARLY_EXIT_EN
    .i_core_halted(core_halted), .o_run_cycles_used(run_used),
`endif
    .o_busy(busy), .o_done(done), .o_pass(pass),
    .o_err_count(err_count), .o_first_fail(first_fail)
  );

  always #5 clk = ~clk;

  // ROM and check table: registered reads
  logic        t_mem [NC];
  logic [31:0] t_idx [NC];
  logic [31:0] t_exp [NC];
  int          t_lat [NC];

  always @(posedge clk) begin
    prog_rdata     <= 32'h100 + 32'(prog_addr);
    bus.chk_is_mem <= t_mem[bus.chk_addr];
    bus.chk_index  <= t_idx[bus.chk_addr];
    bus.chk_expect <= t_exp[bus.chk_addr];
  end

  // Debug port model: response t_lat cycles after dbg_req (0 = never)
  logic [31:0] regs [32];
  logic [31:0] mem  [16];
  logic        dv = 1'b0, pend = 1'b0, glitch = 1'b0;
  logic [31:0] drd = '0, pdata = '0;
  int          cnt = 0;

  function automatic logic [31:0] model_read(input logic is_mem, input logic [31:0] a);
    if (is_mem) return (a < 16) ? mem[a[3:0]] : 32'hEEEE_0001;
    return (a < 32) ? regs[a[4:0]] : 32'hEEEE_0002;
  endfunction

  always @(posedge clk) begin
    dv <= 1'b0;
    if (pend) begin
      if (cnt <= 1) begin dv <= 1'b1; drd <= pdata; pend <= 1'b0; end
      else cnt <= cnt - 1;
    end
    if (bus.dbg_req && t_lat[bus.chk_addr] != 0) begin
      if (t_lat[bus.chk_addr] == 1) begin
        dv  <= 1'b1;
        drd <= model_read(bus.dbg_is_mem, bus.dbg_addr);
      end else begin
        pend  <= 1'b1;
        cnt   <= t_lat[bus.chk_addr] - 1;
        pdata <= model_read(bus.dbg_is_mem, bus.dbg_addr);
      end
    end
  end

  // A garbage strobe coinciding with dbg_req must be ignored by the DUT
  assign bus.dbg_valid = dv | (glitch & bus.dbg_req);
  assign bus.dbg_rdata = (glitch & bus.dbg_req) ? 32'hBAD0_BAD0 : drd;

  // Monitors
  int          cyc = 0, w_cnt = 0, low_cnt = 0, req_cnt = 0, first_low = 0, last_low = 0;
  logic [2:0]  w_addr [16];
  logic [31:0] w_data [16];
  int          w_cyc  [16];
  int          req_cyc[16];
  logic [31:0] mem_dbg_addr = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (imem_we) begin
      if (w_cnt < 16) begin
        w_addr[w_cnt] = imem_addr; w_data[w_cnt] = imem_wdata; w_cyc[w_cnt] = cyc;
      end
      w_cnt = w_cnt + 1;
    end
    if (!core_rst && rst_n) begin
      if (low_cnt == 0) first_low = cyc;
      low_cnt  = low_cnt + 1;
      last_low = cyc;
    end
    if (bus.dbg_req) begin
      if (req_cnt < 16) req_cyc[req_cnt] = cyc;
      req_cnt = req_cnt + 1;
      if (bus.dbg_is_mem && bus.chk_addr == 3'd5) mem_dbg_addr = bus.dbg_addr;
    end
  end

  int checks = 0;
  int errors = 0;
  bit timed_out;

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon;
    w_cnt = 0; low_cnt = 0; req_cnt = 0; first_low = 0; last_low = 0; mem_dbg_addr = '0;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done;
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (done) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic wait_low(input int n);
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (low_cnt >= n) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic set_table_good;
    for (int k = 0; k < 32; k++) regs[k] = 32'hA000 + 32'(k);
    for (int k = 0; k < 16; k++) mem[k]  = 32'h5000 + 32'(k);
    regs[0] = 0; regs[1] = 5; regs[2] = 7; regs[3] = 12; regs[4] = 12; regs[5] = 55;
    mem[2] = 12; mem[8] = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      t_mem[k] = CHK_REG; t_idx[k] = 32'(k + 1);
    end
    t_exp[0] = 5; t_exp[1] = 7; t_exp[2] = 12; t_exp[3] = 12; t_exp[4] = 55;
    t_mem[5] = CHK_MEM; t_idx[5] = 32'd10;          t_exp[5] = 12;
    t_mem[6] = CHK_REG; t_idx[6] = 32'hFFFF_FFE0;   t_exp[6] = 0;
    t_mem[7] = CHK_MEM; t_idx[7] = 32'h23;          t_exp[7] = 32'hDEAD_BEEF;
    for (int k = 0; k < NC; k++) t_lat[k] = 2;
    t_lat[0] = 1;
    glitch = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++; if (core_rst !== 1'b1) begin errors++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
    checks++; if (bus.dbg_req !== 1'b0) begin errors++; $display("FAIL reset_dbg_req: got %b want 0", bus.dbg_req); end
    checks++; if ({busy, done, pass} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busy, done, pass}); end
    checks++; if ({err_count, first_fail} !== 7'd0) begin errors++; $display("FAIL reset_result: got %h want 0", {err_count, first_fail}); end
    checks++; if ({prog_addr, imem_addr, bus.chk_addr} !== 9'd0 || bus.dbg_addr !== 32'd0) begin
      errors++; $display("FAIL reset_addrs: got %h/%h want 0", {prog_addr, imem_addr, bus.chk_addr}, bus.dbg_addr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_pass;
    set_table_good();
    glitch = 1'b1;
    clear_mon();
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pass_busy: got %b want 1", busy); end
    wait_done();
    checks++; if (timed_out) begin errors++; $display("FAIL pass_timeout: got no done want done"); end
    checks++; if (w_cnt != PD) begin errors++; $display("FAIL load_count: got %0d want %0d", w_cnt, PD); end
    for (int k = 0; k < PD; k++) begin
      checks++;
      if (w_addr[k] !== 3'(k) || w_data[k] !== 32'h100 + 32'(k) || w_cyc[k] != w_cyc[0] + k) begin
        errors++;
        $display("FAIL load_word%0d: got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d", k, w_addr[k], w_data[k],
                 w_cyc[k], k, 32'h100 + k, w_cyc[0] + k);
      end
    end
    checks++; if (first_low != w_cyc[PD-1] + HLD + 1) begin errors++; $display("FAIL hold_len: got %0d want %0d", first_low, w_cyc[PD-1] + HLD + 1); end
    checks++; if (low_cnt != RUN || last_low - first_low != RUN - 1) begin errors++; $display("FAIL run_len: got %0d want %0d", low_cnt, RUN); end
    checks++; if (req_cnt != NC) begin errors++; $display("FAIL pass_reqs: got %0d want %0d", req_cnt, NC); end
    checks++; if (req_cyc[0] != last_low + 3) begin errors++; $display("FAIL check_start: got %0d want %0d", req_cyc[0], last_low + 3); end
    checks++; if (mem_dbg_addr !== 32'd2) begin errors++; $display("FAIL mem_dbg_addr: got %0d want 2", mem_dbg_addr); end
    checks++; if ({pass, err_count, first_fail} !== {1'b1, 4'd0, 3'd0}) begin
      errors++; $display("FAIL pass_result: got p=%b e=%0d f=%0d want p=1 e=0 f=0", pass, err_count, first_fail);
    end
    checks++; if (busy !== 1'b0 || core_rst !== 1'b1) begin errors++; $display("FAIL pass_idle: got busy=%b rst=%b want 0 1", busy, core_rst); end
    for (int k = 0; k < 5; k++) tick();
    checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL done_sticky: got d=%b p=%b want 1 1", done, pass); end
  endtask

  task automatic test_mismatch;
    set_table_good();
    t_exp[4] = 99; t_exp[5] = 13;
    clear_mon();
    pulse_start();
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_clear: got d=%b b=%b want 0 1", done, busy); end
    wait_done();
    checks++; if (timed_out) begin errors++; $display("FAIL mismatch_timeout: got no done want done"); end
    checks++; if ({pass, err_count, first_fail} !== {1'b0, 4'd2, 3'd4}) begin
      errors++; $display("FAIL mismatch_result: got p=%b e=%0d f=%0d want p=0 e=2 f=4", pass, err_count, first_fail);
    end
  endtask

  task automatic test_timeout;
    set_table_good();
    t_lat[2] = 0;
    clear_mon();
    pulse_start();
    wait_done();
    checks++; if (timed_out) begin errors++; $display("FAIL tmo_timeout: got no done want done"); end
    checks++; if ({pass, err_count, first_fail} !== {1'b0, 4'd1, 3'd2}) begin
      errors++; $display("FAIL tmo_result: got p=%b e=%0d f=%0d want p=0 e=1 f=2", pass, err_count, first_fail);
    end
    checks++; if (req_cnt != NC) begin errors++; $display("FAIL tmo_reqs: got %0d want %0d", req_cnt, NC); end
    checks++; if (req_cyc[2] - req_cyc[1] != 5) begin errors++; $display("FAIL normal_gap: got %0d want 5", req_cyc[2] - req_cyc[1]); end
    checks++; if (req_cyc[3] - req_cyc[2] != TO + 3) begin errors++; $display("FAIL tmo_gap: got %0d want %0d", req_cyc[3] - req_cyc[2], TO + 3); end
  endtask

  task automatic test_timeout_boundary;
    set_table_good();
    t_lat[1] = TO;
    t_lat[3] = TO + 1;
    clear_mon();
    pulse_start();
    wait_done();
    checks++; if (timed_out) begin errors++; $display("FAIL bound_timeout: got no done want done"); end
    checks++; if ({pass, err_count, first_fail} !== {1'b0, 4'd1, 3'd3}) begin
      errors++; $display("FAIL bound_result: got p=%b e=%0d f=%0d want p=0 e=1 f=3", pass, err_count, first_fail);
    end
  endtask

  task automatic test_reset_abort;
    set_table_good();
    clear_mon();
    pulse_start();
    wait_low(10);
    rst_n = 1'b0;
    #1;
    checks++; if (core_rst !== 1'b1 || busy !== 1'b0 || imem_addr !== 3'd0) begin
      errors++; $display("FAIL abort_state: got rst=%b busy=%b ia=%0d want 1 0 0", core_rst, busy, imem_addr);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || err_count !== 4'd0) begin
      errors++; $display("FAIL abort_no_result: got d=%b b=%b e=%0d want 0 0 0", done, busy, err_count);
    end
    clear_mon();
    pulse_start();
    wait_done();
    checks++; if (timed_out) begin errors++; $display("FAIL rerun_timeout: got no done want done"); end
    checks++; if (w_cnt != PD || w_addr[0] !== 3'd0 || w_data[PD-1] !== 32'h107) begin
      errors++; $display("FAIL rerun_load: got n=%0d a0=%0d d7=%h want %0d 0 107", w_cnt, w_addr[0], w_data[PD-1], PD);
    end
    checks++; if (pass !== 1'b1 || low_cnt != RUN) begin errors++; $display("FAIL rerun_result: got p=%b run=%0d want 1 %0d", pass, low_cnt, RUN); end
  endtask

  task automatic test_start_busy;
    set_table_good();
    clear_mon();
    pulse_start();
    tick(); tick();
    pulse_start();
    wait_low(30);
    pulse_start();
    wait_done();
    checks++; if (timed_out) begin errors++; $display("FAIL busy_timeout: got no done want done"); end
    checks++; if (w_cnt != PD || low_cnt != RUN || req_cnt != NC) begin
      errors++; $display("FAIL busy_restart: got w=%0d run=%0d req=%0d want %0d %0d %0d", w_cnt, low_cnt, req_cnt, PD, RUN, NC);
    end
  endtask

`ifdef SELFTEST_EARLY_EXIT_EN
  task automatic test_early_exit;
    set_table_good();
    clear_mon();
    pulse_start();
    wait_low(20);
    core_halted = 1'b1;
    tick();
    core_halted = 1'b0;
    pulse_start();
    wait_done();
    checks++; if (timed_out) begin errors++; $display("FAIL early_timeout: got no done want done"); end
    checks++; if (low_cnt != 20 || run_used !== 6'd20) begin
      errors++; $display("FAIL early_len: got run=%0d used=%0d want 20 20", low_cnt, run_used);
    end
    checks++; if (req_cyc[0] != last_low + 3) begin errors++; $display("FAIL early_check_start: got %0d want %0d", req_cyc[0], last_low + 3); end
    checks++; if (pass !== 1'b1 || w_cnt != PD || req_cnt != NC) begin
      errors++; $display("FAIL early_result: got p=%b w=%0d req=%0d want 1 %0d %0d", pass, w_cnt, req_cnt, PD, NC);
    end
  endtask
`endif

  initial begin
    set_table_good();
    #2;
    test_reset();
    test_load_pass();
    test_mismatch();
    test_timeout();
    test_timeout_boundary();
    test_reset_abort();
    test_start_busy();
`ifdef SELFTEST_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
